// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the device-to-host receiver.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      XFER,
      WAIT_IDLE,
      ABORT
   } ps2_state_e;

   // start + 8 data + parity + stop
   localparam int FRAME_BITS = 11;

   function automatic logic [63:0] us_to_cycles(input int unsigned us, input int unsigned clk_hz);
      return (64'(us) * 64'(clk_hz)) / 64'd1_000_000;
   endfunction

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and status between control logic and the PS/2 host transmitter.
interface ps2_host_tx_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       ack_err;
   logic       timeout;
   logic       rx_inhibit;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, busy, done, ack_err, timeout, rx_inhibit
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, busy, done, ack_err, timeout, rx_inhibit
   );

endinterface

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 pins and glitch-filters the clock line.
// clk_fall strobes for one cycle when the filtered clock goes 1 -> 0.
module ps2_line_filter
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic clk_raw,
   input  logic dat_raw,
   output logic clk_filt,
   output logic dat_sync,
   output logic clk_fall
);

   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(FILTER_LEN - 1);

   logic             clk_meta_q, clk_meta_d;
   logic             clk_sync_q, clk_sync_d;
   logic             dat_meta_q, dat_meta_d;
   logic             dat_sync_q, dat_sync_d;
   logic             filt_q, filt_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      clk_meta_d = clk_raw;
      clk_sync_d = clk_meta_q;
      dat_meta_d = dat_raw;
      dat_sync_d = dat_meta_q;
      filt_d     = filt_q;
      cnt_d      = '0;
      // a new level is accepted only after FILTER_LEN consecutive differing samples
      if (clk_sync_q != filt_q) begin
         if (cnt_q == CNT_TC) begin
            filt_d = clk_sync_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      fall_d = filt_q & ~filt_d;
   end

   // idle bus level is high, so everything resets to 1 to avoid a bogus edge
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
         filt_q     <= 1'b1;
         fall_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         clk_meta_q <= clk_meta_d;
         clk_sync_q <= clk_sync_d;
         dat_meta_q <= dat_meta_d;
         dat_sync_q <= dat_sync_d;
         filt_q     <= filt_d;
         fall_q     <= fall_d;
         cnt_q      <= cnt_d;
      end
   end

   assign clk_filt = filt_q;
   assign dat_sync = dat_sync_q;
   assign clk_fall = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte and reports done, NACK or timeout.
//
// state     | meaning
// IDLE      | bus released, ready for a command byte
// INHIBIT   | clock held low; data pulled low on the last cycle (start bit)
// REQ       | clock released, waiting for the device's first falling edge
// XFER      | data/parity/stop change on device clock falls, ack sampled on fall 11
// WAIT_IDLE | lines released, waiting for clock and data to both read high
// ABORT     | single cycle: timeout pulse, then IDLE
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_HZ        = 50_000_000,
   parameter int unsigned INHIBIT_US    = 120,
   parameter int unsigned START_TMO_US  = 15000,
   parameter int unsigned PACKET_TMO_US = 2000,
   parameter int          FILTER_LEN    = 8
) (
   input  logic          CLOCK_50,
   input  logic          reset_n,
   ps2_host_tx_if.slave  bus,
   input  logic          ps2_clk_in,
   input  logic          ps2_dat_in,
   output logic          ps2_clk_oe,
   output logic          ps2_dat_oe
);

   localparam logic [63:0] INHIBIT_CYC = us_to_cycles(INHIBIT_US, CLK_HZ);
   localparam logic [63:0] START_CYC   = us_to_cycles(START_TMO_US, CLK_HZ);
   localparam logic [63:0] PACKET_CYC  = us_to_cycles(PACKET_TMO_US, CLK_HZ);
   localparam logic [63:0] MAX_SP      = (START_CYC > PACKET_CYC) ? START_CYC : PACKET_CYC;
   localparam logic [63:0] MAX_CYC     = (MAX_SP > INHIBIT_CYC) ? MAX_SP : INHIBIT_CYC;
   localparam int          TMR_W       = $clog2(MAX_CYC);

   localparam logic [TMR_W-1:0] INHIBIT_LD = TMR_W'(INHIBIT_CYC - 64'd1);
   localparam logic [TMR_W-1:0] START_LD   = TMR_W'(START_CYC - 64'd1);
   localparam logic [TMR_W-1:0] PACKET_LD  = TMR_W'(PACKET_CYC - 64'd1);
   localparam logic [3:0]       STOP_CNT   = 4'(FRAME_BITS - 2);
   localparam logic [3:0]       ACK_CNT    = 4'(FRAME_BITS - 1);

   ps2_state_e       state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [8:0]       shift_q, shift_d;
   logic             clk_oe_q, clk_oe_d;
   logic             dat_oe_q, dat_oe_d;
   logic             done_q, done_d;
   logic             ack_err_q, ack_err_d;
   logic             timeout_q, timeout_d;

   logic clk_filt;
   logic dat_sync;
   logic clk_fall;

   ps2_line_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_filter (
      .clk_sys  (CLOCK_50),
      .rst_b    (reset_n),
      .clk_raw  (ps2_clk_in),
      .dat_raw  (ps2_dat_in),
      .clk_filt (clk_filt),
      .dat_sync (dat_sync),
      .clk_fall (clk_fall)
   );

   always_comb begin
      state_d   = state_q;
      tmr_d     = (tmr_q != '0) ? tmr_q - TMR_W'(1) : tmr_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      clk_oe_d  = clk_oe_q;
      dat_oe_d  = dat_oe_q;
      done_d    = 1'b0;
      ack_err_d = 1'b0;
      timeout_d = 1'b0;

      case (state_q)
         IDLE: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            if (bus.tx_valid) begin
               shift_d  = {odd_parity(bus.tx_data), bus.tx_data};
               tmr_d    = INHIBIT_LD;
               cnt_d    = '0;
               clk_oe_d = 1'b1;
               dat_oe_d = (INHIBIT_LD == '0);
               state_d  = INHIBIT;
            end
         end
         INHIBIT: begin
            // outputs are registered, so the start bit is requested one cycle early
            if (tmr_q == '0) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b1;
               tmr_d    = START_LD;
               state_d  = REQ;
            end else if (tmr_q == TMR_W'(1)) begin
               dat_oe_d = 1'b1;
            end
         end
         REQ: begin
            if (tmr_q == '0) begin
               clk_oe_d  = 1'b0;
               dat_oe_d  = 1'b0;
               timeout_d = 1'b1;
               state_d   = ABORT;
            end else if (clk_fall) begin
               dat_oe_d = ~shift_q[0];
               shift_d  = {1'b0, shift_q[8:1]};
               cnt_d    = 4'd1;
               tmr_d    = PACKET_LD;
               state_d  = XFER;
            end
         end
         XFER: begin
            if (tmr_q == '0) begin
               clk_oe_d  = 1'b0;
               dat_oe_d  = 1'b0;
               timeout_d = 1'b1;
               state_d   = ABORT;
            end else if (clk_fall) begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q < STOP_CNT) begin
                  dat_oe_d = ~shift_q[0];
                  shift_d  = {1'b0, shift_q[8:1]};
               end else if (cnt_q == STOP_CNT) begin
                  dat_oe_d = 1'b0;
               end else if (cnt_q == ACK_CNT) begin
                  dat_oe_d  = 1'b0;
                  done_d    = ~dat_sync;
                  ack_err_d = dat_sync;
                  state_d   = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            if (tmr_q == '0) begin
               timeout_d = 1'b1;
               state_d   = ABORT;
            end else if (clk_filt && dat_sync) begin
               state_d = IDLE;
            end
         end
         ABORT: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = IDLE;
         end
         default: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = IDLE;
         end
      endcase
   end

   // async reset drops both open-drain enables without waiting for a clock
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         tmr_q     <= '0;
         cnt_q     <= '0;
         shift_q   <= '0;
         clk_oe_q  <= 1'b0;
         dat_oe_q  <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         clk_oe_q  <= clk_oe_d;
         dat_oe_q  <= dat_oe_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.tx_ready   = (state_q == IDLE);
   assign bus.busy       = (state_q != IDLE);
   assign bus.rx_inhibit = (state_q != IDLE);
   assign bus.done       = done_q;
   assign bus.ack_err    = ack_err_q;
   assign bus.timeout    = timeout_q;
   assign ps2_clk_oe     = clk_oe_q;
   assign ps2_dat_oe     = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus plus a PS/2 device model that clocks, samples and acks.
module tb_ps2_host_tx;

   localparam int CLK_HZ        = 1_000_000;
   localparam int INHIBIT_US    = 120;
   localparam int START_TMO_US  = 15000;
   localparam int PACKET_TMO_US = 2000;
   localparam int INH_CYC       = INHIBIT_US * (CLK_HZ / 1_000_000);
   localparam int START_CYC     = START_TMO_US * (CLK_HZ / 1_000_000);
   localparam int PACKET_CYC    = PACKET_TMO_US * (CLK_HZ / 1_000_000);

   logic CLOCK_50;
   logic reset_n;
   logic ps2_clk_in, ps2_dat_in;
   logic ps2_clk_oe, ps2_dat_oe;
   logic dev_clk_low, dev_dat_low;

   ps2_host_tx_if bus ();

   ps2_host_tx #(
      .CLK_HZ        (CLK_HZ),
      .INHIBIT_US    (INHIBIT_US),
      .START_TMO_US  (START_TMO_US),
      .PACKET_TMO_US (PACKET_TMO_US),
      .FILTER_LEN    (8)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .reset_n    (reset_n),
      .bus        (bus),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe)
   );

   // wired-AND open-drain lines with pull-ups
   assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int tmo_cnt  = 0;
   int viol_cnt = 0;

   always @(negedge CLOCK_50) begin
      if (bus.done === 1'b1)    done_cnt <= done_cnt + 1;
      if (bus.ack_err === 1'b1) err_cnt  <= err_cnt + 1;
      if (bus.timeout === 1'b1) tmo_cnt  <= tmo_cnt + 1;
      if ((bus.tx_ready === 1'b1) && (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0))
         viol_cnt <= viol_cnt + 1;
      if ((bus.busy !== ~bus.tx_ready) || (bus.rx_inhibit !== bus.busy))
         viol_cnt <= viol_cnt + 1;
   end

   typedef struct {
      logic [7:0] data;
      bit         ack_ok;
      int         half;
      bit         glitch;
      bit         exp_par;
      int         exp_done;
      int         exp_err;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   // reference frame: start 0, data LSB first, odd parity, stop 1
   function automatic logic [10:0] model_frame(input logic [7:0] d);
      int   ones = $countones(d);
      logic par  = ((ones % 2) == 0);
      return {1'b1, par, d, 1'b0};
   endfunction

   task automatic send_byte(input logic [7:0] data);
      bus.tx_data  = data;
      bus.tx_valid = 1'b1;
      cyc(1);
      bus.tx_valid = 1'b0;
   endtask

   task automatic wait_clk_release();
      int i = 0;
      while (ps2_clk_oe !== 1'b1 && i < 10) begin cyc(1); i++; end
      i = 0;
      while (ps2_clk_oe === 1'b1 && i < 1000) begin cyc(1); i++; end
   endtask

   // device side: seen[0] start, seen[8:1] data, seen[9] parity, seen[10] stop
   task automatic dev_frame(input int half, input bit ack_ok, input int n_clk,
                            input bit glitch, output logic [10:0] seen);
      seen    = '1;
      seen[0] = ps2_dat_in;
      for (int k = 1; k <= n_clk; k++) begin
         dev_clk_low = 1'b1;
         cyc(half);
         if (k <= 10) seen[k] = ps2_dat_in;
         dev_clk_low = 1'b0;
         if (k == 10) begin
            cyc(half / 2);
            dev_dat_low = ack_ok;
            cyc(half - half / 2);
         end else if (k == 11) begin
            cyc(2);
            dev_dat_low = 1'b0;
            cyc(half - 2);
         end else if (glitch && (k == 3 || k == 6)) begin
            cyc(half / 2);
            dev_clk_low = 1'b1;
            cyc(2);
            dev_clk_low = 1'b0;
            cyc(half - half / 2 - 2);
         end else begin
            cyc(half);
         end
      end
   endtask

   task automatic run_frame(input logic [7:0] data, input bit ack_ok, input int half,
                            input bit glitch, input bit exp_par, input int exp_done,
                            input int exp_err, input string tag);
      int n, both, i, snap_d, snap_e, snap_t;
      logic [10:0] seen;
      snap_d = done_cnt;
      snap_e = err_cnt;
      snap_t = tmo_cnt;
      send_byte(data);
      check({tag, " busy_after_req"}, bus.busy, 1);
      i = 0;
      while (ps2_clk_oe !== 1'b1 && i < 10) begin cyc(1); i++; end
      n    = 0;
      both = 0;
      while (ps2_clk_oe === 1'b1 && n < 1000) begin
         n++;
         if (ps2_dat_oe === 1'b1) both++;
         cyc(1);
      end
      check({tag, " inhibit_cycles"}, n, INH_CYC);
      check({tag, " start_overlap"}, both, 1);
      check({tag, " start_driven"}, ps2_dat_oe, 1);
      if (glitch) begin
         bus.tx_data  = ~data;
         bus.tx_valid = 1'b1;
         cyc(3);
         bus.tx_valid = 1'b0;
         bus.tx_data  = data;
         cyc(17);
      end else begin
         cyc(20);
      end
      dev_frame(half, ack_ok, 11, glitch, seen);
      check({tag, " frame"}, seen, model_frame(data));
      check({tag, " parity"}, seen[9], exp_par);
      i = 0;
      while (bus.tx_ready !== 1'b1 && i < 300) begin cyc(1); i++; end
      cyc(2);
      check({tag, " ready_after"}, bus.tx_ready, 1);
      check({tag, " oe_released"}, {ps2_clk_oe, ps2_dat_oe}, 0);
      check({tag, " done_pulses"}, done_cnt - snap_d, exp_done);
      check({tag, " nack_pulses"}, err_cnt - snap_e, exp_err);
      check({tag, " timeout_pulses"}, tmo_cnt - snap_t, 0);
   endtask

   task automatic poll_timeout(input int limit, output int t);
      t = 0;
      for (int i = 0; i < limit; i++) begin
         cyc(1);
         if (bus.timeout === 1'b1) begin
            t = i + 1;
            break;
         end
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t, snap_d, snap_e;
      logic [10:0] seen;
      logic [7:0]  rd;
      bit          rack;

      vecs[0] = '{data: 8'hF4, ack_ok: 1'b1, half: 40, glitch: 1'b0, exp_par: 1'b0, exp_done: 1, exp_err: 0};
      vecs[1] = '{data: 8'h00, ack_ok: 1'b1, half: 40, glitch: 1'b0, exp_par: 1'b1, exp_done: 1, exp_err: 0};
      vecs[2] = '{data: 8'hFF, ack_ok: 1'b1, half: 30, glitch: 1'b0, exp_par: 1'b1, exp_done: 1, exp_err: 0};
      vecs[3] = '{data: 8'hA5, ack_ok: 1'b0, half: 40, glitch: 1'b0, exp_par: 1'b1, exp_done: 0, exp_err: 1};
      vecs[4] = '{data: 8'h3C, ack_ok: 1'b1, half: 40, glitch: 1'b1, exp_par: 1'b1, exp_done: 1, exp_err: 0};

      reset_n      = 1'b0;
      dev_clk_low  = 1'b0;
      dev_dat_low  = 1'b0;
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b0;
      cyc(3);
      check("reset tx_ready", bus.tx_ready, 1);
      check("reset busy", bus.busy, 0);
      check("reset pulses", {bus.done, bus.ack_err, bus.timeout}, 0);
      check("reset oe", {ps2_clk_oe, ps2_dat_oe}, 0);
      check("reset rx_inhibit", bus.rx_inhibit, 0);
      reset_n = 1'b1;
      cyc(5);

      for (int v = 0; v < 5; v++)
         run_frame(vecs[v].data, vecs[v].ack_ok, vecs[v].half, vecs[v].glitch,
                   vecs[v].exp_par, vecs[v].exp_done, vecs[v].exp_err,
                   $sformatf("vec%0d", v));

      for (int r = 0; r < 8; r++) begin
         rd   = 8'($urandom_range(0, 255));
         rack = 1'($urandom_range(0, 1));
         run_frame(rd, rack, int'($urandom_range(20, 45)), 1'($urandom_range(0, 1)),
                   model_frame(rd) >> 9, int'(rack), int'(!rack), $sformatf("rnd%0d", r));
      end

      // device never clocks: start timeout
      snap_d = done_cnt;
      snap_e = err_cnt;
      send_byte(8'h5A);
      poll_timeout(INH_CYC + START_CYC + 500, t);
      check_range("start_tmo cycles", t, INH_CYC + START_CYC - 5, INH_CYC + START_CYC + 20);
      check("start_tmo oe", {ps2_clk_oe, ps2_dat_oe}, 0);
      cyc(1);
      check("start_tmo ready", bus.tx_ready, 1);
      check("start_tmo no done/nack", (done_cnt - snap_d) + (err_cnt - snap_e), 0);

      // device stops after five clocks: packet timeout measured from first fall
      snap_d = done_cnt;
      send_byte(8'hF4);
      wait_clk_release();
      cyc(20);
      dev_frame(40, 1'b1, 5, 1'b0, seen);
      poll_timeout(PACKET_CYC + 500, t);
      if (t != 0) t = t + 5 * 80;
      check_range("packet_tmo cycles", t, PACKET_CYC, PACKET_CYC + 40);
      check("packet_tmo oe", {ps2_clk_oe, ps2_dat_oe}, 0);
      cyc(1);
      check("packet_tmo ready", bus.tx_ready, 1);
      check("packet_tmo no done", done_cnt - snap_d, 0);

      // async reset during fall 4 while data is being driven low
      send_byte(8'h00);
      wait_clk_release();
      cyc(20);
      dev_frame(40, 1'b1, 3, 1'b0, seen);
      dev_clk_low = 1'b1;
      cyc(20);
      check("midreset dat driven", ps2_dat_oe, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("midreset oe released", {ps2_clk_oe, ps2_dat_oe}, 0);
      dev_clk_low = 1'b0;
      cyc(3);
      reset_n = 1'b1;
      cyc(1);
      check("midreset ready", bus.tx_ready, 1);
      check("midreset busy", bus.busy, 0);

      // one clean frame after the reset
      run_frame(8'hFF, 1'b1, 40, 1'b0, 1'b1, 1, 0, "post_reset");

      cyc(5);
      check("oe/ready/busy invariants", viol_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
